// File: rtl/activation_relu_quant_pkg.sv
// ---------------------------------------------------------------------------
// activation_relu_quant_pkg
//   Shared widths and constants for the post-convolution activation path of
//   the VGG-16 accelerator.  The defaults describe the widest layer; narrower
//   layers override OFM_BIT (21..29) when instantiating the activation block.
//
//   OFM_BIT_DEFAULT  signed accumulator width feeding the activation
//   IFM_BIT_DEFAULT  unsigned activation width handed to the next layer
//   SHIFT_DEFAULT    requantization right-shift amount
//   ACT_MAX          largest representable activation, 2^IFM_BIT-1
//   act_max()        same limit for an arbitrary activation width
// ---------------------------------------------------------------------------
package activation_relu_quant_pkg;

    localparam int OFM_BIT_DEFAULT = 29;
    localparam int IFM_BIT_DEFAULT = 8;
    localparam int SHIFT_DEFAULT   = 13;

    function automatic int act_max(input int ifm_bit);
        return (1 << ifm_bit) - 1;
    endfunction

    localparam int ACT_MAX = act_max(IFM_BIT_DEFAULT);

endpackage

// File: rtl/activation_relu_quant_round_shift_sat.sv
// ---------------------------------------------------------------------------
// round_shift_sat
//   Combinational requantizer shared by the accelerator's requantizing blocks.
//   It is split into two halves so the caller can place a register between
//   them: the round half adds 2^(SHIFT-1) (round half up), and the
//   shift/saturate half drops SHIFT LSBs and clamps to the activation range.
//
//   value        in   OFM_BIT    non-negative value to requantize
//   rounded      out  OFM_BIT+1  value + rounding bias, one bit wider so it
//                                can never wrap
//   rounded_reg  in   OFM_BIT+1  (registered) rounded value to shift
//   result       out  IFM_BIT    shifted and saturated activation
// ---------------------------------------------------------------------------
module round_shift_sat
    import activation_relu_quant_pkg::*;
#(
    parameter int OFM_BIT = OFM_BIT_DEFAULT,
    parameter int IFM_BIT = IFM_BIT_DEFAULT,
    parameter int SHIFT   = SHIFT_DEFAULT
) (
    input  logic [OFM_BIT-1:0] value,
    output logic [OFM_BIT:0]   rounded,
    input  logic [OFM_BIT:0]   rounded_reg,
    output logic [IFM_BIT-1:0] result
);

    // A zero shift needs no rounding; BIAS_POS keeps the shift amount legal
    // even when SHIFT is 0 so the constant expression stays well defined.
    localparam int               BIAS_POS   = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic [OFM_BIT:0] ROUND_BIAS = (SHIFT > 0) ? ((OFM_BIT + 1)'(1) << BIAS_POS)
                                                          : '0;
    localparam logic [OFM_BIT:0] SAT_LIMIT  = (OFM_BIT + 1)'(act_max(IFM_BIT));

    logic [OFM_BIT:0] shifted;

    assign rounded = {1'b0, value} + ROUND_BIAS;
    assign shifted = rounded_reg >> SHIFT;

    // Anything above the activation range clamps to all ones.
    always_comb begin
        result = shifted[IFM_BIT-1:0];
        if (shifted > SAT_LIMIT) begin
            result = '1;
        end
    end

endmodule

// File: rtl/activation_relu_quant.sv
// ---------------------------------------------------------------------------
// activation_relu_quant
//   ReLU followed by round/shift/saturate requantization of one signed OFM
//   sample per cycle into an unsigned activation for the next layer.  Two
//   register stages, one sample per cycle, no backpressure.
//
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous reset, active HIGH despite the name
//   in_valid    in   1        OFM carries a sample this cycle
//   OFM         in   OFM_BIT  signed convolution result
//   out_valid   out  1        Activation carries a result this cycle
//   Activation  out  IFM_BIT  quantized activation, 0 whenever out_valid==0
// ---------------------------------------------------------------------------
module activation_relu_quant
    import activation_relu_quant_pkg::*;
#(
    parameter int OFM_BIT = OFM_BIT_DEFAULT,
    parameter int IFM_BIT = IFM_BIT_DEFAULT,
    parameter int SHIFT   = SHIFT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [OFM_BIT-1:0] OFM,
    output logic                      out_valid,
    output logic        [IFM_BIT-1:0] Activation
);

    logic [OFM_BIT-1:0] relu_value;
    logic [OFM_BIT:0]   rounded;
    logic [OFM_BIT:0]   stage1_data;
    logic               stage1_valid;
    logic [IFM_BIT-1:0] sat_result;

    // Negative inputs, including the most negative code, collapse to zero.
    assign relu_value = OFM[OFM_BIT-1] ? '0 : OFM;

    round_shift_sat #(
        .OFM_BIT (OFM_BIT),
        .IFM_BIT (IFM_BIT),
        .SHIFT   (SHIFT)
    ) u_round_shift_sat (
        .value       (relu_value),
        .rounded     (rounded),
        .rounded_reg (stage1_data),
        .result      (sat_result)
    );

    // Stage 1 holds the rounded ReLU value; the data register only loads on
    // a valid sample so idle cycles do not toggle it.
    // Stage 2 holds the final activation, forced to zero when not valid.
    // Reset wins over a same-cycle in_valid and drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stage1_valid <= 1'b0;
            stage1_data  <= '0;
            out_valid    <= 1'b0;
            Activation   <= '0;
        end else begin
            stage1_valid <= in_valid;
            if (in_valid) begin
                stage1_data <= rounded;
            end
            out_valid  <= stage1_valid;
            Activation <= stage1_valid ? sat_result : '0;
        end
    end

endmodule

// File: tb/tb_activation_relu_quant.sv
// ---------------------------------------------------------------------------
// tb_activation_relu_quant
//   Self-checking bench for activation_relu_quant with default parameters.
//   Inputs change 1 time unit after a rising edge; outputs are read at the
//   same point, i.e. they reflect the registers loaded by that edge.
// ---------------------------------------------------------------------------
module tb_activation_relu_quant;

    localparam int OFM_BIT = 29;
    localparam int IFM_BIT = 8;
    localparam int SHIFT   = 13;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic signed [OFM_BIT-1:0] OFM;
    logic                      out_valid;
    logic        [IFM_BIT-1:0] Activation;

    int checks;
    int failures;

    activation_relu_quant #(
        .OFM_BIT (OFM_BIT),
        .IFM_BIT (IFM_BIT),
        .SHIFT   (SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .OFM        (OFM),
        .out_valid  (out_valid),
        .Activation (Activation)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard: the stimulus is bounded, so this only fires on a hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: ReLU, add half an LSB of the output grid, floor-divide by
    // 2^SHIFT, clamp to the activation range.
    function automatic int ref_act(input longint ofm);
        longint v;
        longint lim;
        lim = (longint'(1) << IFM_BIT) - 1;
        v = (ofm < 0) ? 0 : ofm;
        if (SHIFT > 0) v = v + (longint'(1) << (SHIFT - 1));
        v = v / (longint'(1) << SHIFT);
        if (v > lim) v = lim;
        return int'(v);
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of input and clock it in.
    task automatic applyStimulus(input logic v, input logic signed [OFM_BIT-1:0] d);
        in_valid = v;
        OFM      = d;
        tick();
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0);
    endtask

    function automatic logic signed [OFM_BIT-1:0] rand_ofm();
        int sel;
        int mag;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       mag = int'($urandom);
            1:       mag = int'($urandom_range(0, 3 * 8192));
            2:       mag = int'($urandom_range(2070000, 2100000));
            default: mag = -int'($urandom_range(1, 32'h0FFF_FFFF));
        endcase
        return OFM_BIT'(mag);
    endfunction

    task automatic test_reset();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            OFM = rand_ofm();
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_valid[%0d]: got %b, required 0", i, out_valid);
            end
            checks++;
            if (Activation !== '0) begin
                failures++;
                $display("[TB] FAIL reset_act[%0d]: got %0d, required 0", i, Activation);
            end
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, '0);
            checks++;
            if (out_valid !== 1'b0 || Activation !== '0) begin
                failures++;
                $display("[TB] FAIL post_reset_idle[%0d]: got valid=%b act=%0d, required 0/0",
                         i, out_valid, Activation);
            end
        end
    endtask

    task automatic test_directed();
        int ofm_tbl [11] = '{0, -1, -268435456, 4095, 4096, 8192, 12288,
                             2088959, 2093056, 268435455, 2080767};
        int exp_tbl [11] = '{0, 0, 0, 0, 1, 1, 2, 255, 255, 255, 254};
        flush();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, OFM_BIT'(ofm_tbl[i]));
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL directed_early[%0d]: out_valid=%b one cycle after input, required 0",
                         ofm_tbl[i], out_valid);
            end
            applyStimulus(1'b0, rand_ofm());
            checks++;
            if (out_valid !== 1'b1 || Activation !== IFM_BIT'(exp_tbl[i])) begin
                failures++;
                $display("[TB] FAIL directed[%0d]: got valid=%b act=%0d, required 1/%0d",
                         ofm_tbl[i], out_valid, Activation, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic vin  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int   din  [6] = '{8192, 16384, 0, 24576, 0, 0};
        logic vexp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        int   aexp [6] = '{0, 1, 2, 0, 3, 0};
        flush();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vin[i], vin[i] ? OFM_BIT'(din[i]) : rand_ofm());
            checks++;
            if (out_valid !== vexp[i] || Activation !== IFM_BIT'(aexp[i])) begin
                failures++;
                $display("[TB] FAIL stream[%0d]: got valid=%b act=%0d, required %b/%0d",
                         i, out_valid, Activation, vexp[i], aexp[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic signed [OFM_BIT-1:0] c;
        flush();
        applyStimulus(1'b1, OFM_BIT'(8192));
        applyStimulus(1'b1, OFM_BIT'(16384));
        // The second sample sits in stage 1 when reset lands and must vanish.
        rst_n = 1'b1;
        applyStimulus(1'b0, '0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || Activation !== '0) begin
                failures++;
                $display("[TB] FAIL midreset_drop[%0d]: got valid=%b act=%0d, required 0/0",
                         i, out_valid, Activation);
            end
            applyStimulus(1'b0, '0);
        end
        c = OFM_BIT'(int'($urandom_range(0, 2100000)));
        applyStimulus(1'b1, c);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_early: got valid=%b, required 0", out_valid);
        end
        applyStimulus(1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || Activation !== IFM_BIT'(ref_act(longint'(c)))) begin
            failures++;
            $display("[TB] FAIL midreset_new: got valid=%b act=%0d, required 1/%0d",
                     out_valid, Activation, ref_act(longint'(c)));
        end
    endtask

    task automatic test_random();
        logic                      prev_v;
        logic signed [OFM_BIT-1:0] prev_d;
        logic                      v;
        logic signed [OFM_BIT-1:0] d;
        int                        exp_act;
        flush();
        prev_v = 1'b0;
        prev_d = '0;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) < 7);
            d = rand_ofm();
            applyStimulus(v, d);
            exp_act = prev_v ? ref_act(longint'(prev_d)) : 0;
            checks++;
            if (out_valid !== prev_v || Activation !== IFM_BIT'(exp_act)) begin
                failures++;
                $display("[TB] FAIL random[%0d]: got valid=%b act=%0d, required %b/%0d (ofm=%0d)",
                         i, out_valid, Activation, prev_v, exp_act, prev_d);
            end
            prev_v = v;
            prev_d = d;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        OFM      = '0;
        test_reset();
        test_directed();
        test_stream();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
